// File: rtl/custom_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one custom execution unit between two requesters.
// Latency: accept -> response valid in 3 cycles minimum; a unit that never answers aborts after TIMEOUT_CYC WAIT cycles.
// Backpressure: one op in flight; requests stall outside IDLE and the response holds until the owner takes it.
module custom_unit_arbiter #(
    parameter int          OP_W        = 7,
    parameter int          DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [OP_W-1:0]   req0_op_i,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [OP_W-1:0]   req1_op_i,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic              cu_enable_o,
    output logic [OP_W-1:0]   cu_operator_o,
    output logic [DATA_W-1:0] cu_operand_a_o,
    output logic [DATA_W-1:0] cu_operand_b_o,
    input  logic [DATA_W-1:0] cu_result_i,
    input  logic              cu_ready_i
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);

    logic [2:0]  state;
    logic        owner;
    logic        last_grant;
    logic        drain;
    logic [15:0] wdog;
    logic [15:0] wdog_next;
    logic        grant_vld;
    logic        grant;
    logic        accept_ok;
    logic        rsp_taken;

    always_comb begin
        grant_vld = req0_valid_i | req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid_i;
        end
    end

    // Ready is gated by reset so the combinational path stays quiet while rst is held.
    assign accept_ok    = (state == S_IDLE) && !rst && grant_vld;
    assign req0_ready_o = accept_ok && !grant;
    assign req1_ready_o = accept_ok && grant;

    assign cu_enable_o  = (state == S_ISSUE);
    assign rsp0_valid_o = (state == S_RESP) && !owner;
    assign rsp1_valid_o = (state == S_RESP) && owner;
    assign rsp_taken    = owner ? rsp1_ready_i : rsp0_ready_i;

    assign wdog_next = (wdog == 16'hFFFF) ? wdog : wdog + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            owner          <= 1'b0;
            last_grant     <= 1'b1;
            drain          <= 1'b0;
            wdog           <= '0;
            rsp_data_o     <= '0;
            rsp_err_o      <= 1'b0;
            cu_operator_o  <= '0;
            cu_operand_a_o <= '0;
            cu_operand_b_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        cu_operator_o  <= grant ? req1_op_i : req0_op_i;
                        cu_operand_a_o <= grant ? req1_a_i  : req0_a_i;
                        cu_operand_b_o <= grant ? req1_b_i  : req0_b_i;
                        owner          <= grant;
                        last_grant     <= grant;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wdog  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cu_ready_i) begin
                        rsp_data_o <= cu_result_i;
                        rsp_err_o  <= 1'b0;
                        state      <= S_RESP;
                    end else begin
                        wdog <= wdog_next;
                        // Abort still leaves the unit busy, so drain before reissuing.
                        if (wdog_next == TIMEOUT_LIM) begin
                            rsp_data_o <= '0;
                            rsp_err_o  <= 1'b1;
                            drain      <= 1'b1;
                            state      <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_taken) begin
                        state <= drain ? S_DRAIN : S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (cu_ready_i) begin
                        drain <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_custom_unit_arbiter.sv
// Directed bench for custom_unit_arbiter with a transaction-level reference model checked every cycle.
module tb_custom_unit_arbiter;

    localparam int OP_W   = 7;
    localparam int DATA_W = 32;
    localparam int TO     = 8;
    localparam logic [OP_W-1:0] ALU_SLTS = 7'd3;
    localparam logic [OP_W-1:0] ALU_CLB  = 7'd40;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic              req0_ready_o, req1_ready_o;
    logic [OP_W-1:0]   req0_op_i = '0, req1_op_i = '0;
    logic [DATA_W-1:0] req0_a_i = '0, req0_b_i = '0, req1_a_i = '0, req1_b_i = '0;
    logic              rsp0_valid_o, rsp1_valid_o;
    logic              rsp0_ready_i = 1'b1, rsp1_ready_i = 1'b1;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_err_o;
    logic              cu_enable_o;
    logic [OP_W-1:0]   cu_operator_o;
    logic [DATA_W-1:0] cu_operand_a_o, cu_operand_b_o;
    logic [DATA_W-1:0] cu_result_i = '0;
    logic              cu_ready_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    custom_unit_arbiter #(.OP_W(OP_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op_i),
        .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op_i),
        .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
        .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
        .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .cu_enable_o(cu_enable_o), .cu_operator_o(cu_operator_o),
        .cu_operand_a_o(cu_operand_a_o), .cu_operand_b_o(cu_operand_b_o),
        .cu_result_i(cu_result_i), .cu_ready_i(cu_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: one operation tracked by its age in cycles since acceptance.
    bit              m_inflight = 0, m_resp = 0, m_drain = 0, m_owner = 0, m_last = 1;
    int              m_age = 0;
    logic [OP_W-1:0] m_op = '0;
    logic [31:0]     m_a = '0, m_b = '0, m_data = '0;
    bit              m_err = 0;
    bit              m_idle, m_gvld, m_g;

    always @(negedge clk) begin
        if (rst) begin
            m_inflight = 0; m_resp = 0; m_drain = 0; m_owner = 0; m_last = 1; m_age = 0;
            m_op = '0; m_a = '0; m_b = '0; m_data = '0; m_err = 0;
        end
        m_idle = !m_inflight && !m_resp && !m_drain;
        m_gvld = req0_valid_i || req1_valid_i;
        m_g    = (req0_valid_i && req1_valid_i) ? !m_last : req1_valid_i;
        check("m_rdy0",  req0_ready_o, !rst && m_idle && m_gvld && !m_g);
        check("m_rdy1",  req1_ready_o, !rst && m_idle && m_gvld && m_g);
        check("m_en",    cu_enable_o,  m_inflight && m_age == 1);
        check("m_rv0",   rsp0_valid_o, m_resp && !m_owner);
        check("m_rv1",   rsp1_valid_o, m_resp && m_owner);
        check("m_data",  rsp_data_o,   m_data);
        check("m_err",   rsp_err_o,    m_err);
        check("m_op",    cu_operator_o, m_op);
        check("m_a",     cu_operand_a_o, m_a);
        check("m_b",     cu_operand_b_o, m_b);
        if (!rst) begin
            if (m_idle) begin
                if (m_gvld) begin
                    m_inflight = 1; m_age = 1; m_owner = m_g; m_last = m_g;
                    m_op = m_g ? req1_op_i : req0_op_i;
                    m_a  = m_g ? req1_a_i  : req0_a_i;
                    m_b  = m_g ? req1_b_i  : req0_b_i;
                end
            end else if (m_inflight) begin
                if (m_age == 1) begin
                    m_age = 2;
                end else if (cu_ready_i) begin
                    m_data = cu_result_i; m_err = 0; m_inflight = 0; m_resp = 1;
                end else if (m_age - 1 >= TO) begin
                    m_data = '0; m_err = 1; m_inflight = 0; m_resp = 1; m_drain = 1;
                end else begin
                    m_age++;
                end
            end else if (m_resp) begin
                if (m_owner ? rsp1_ready_i : rsp0_ready_i) m_resp = 0;
            end else if (m_drain) begin
                if (cu_ready_i) m_drain = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit exp_order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int n;
        #1 rst = 1'b1;
        step(2);
        // Single-cycle op from req0, requests presented while reset is still held.
        req0_valid_i = 1; req0_op_i = ALU_SLTS; req0_a_i = 5; req0_b_i = 7;
        cu_ready_i = 1; cu_result_i = 10;
        #1;
        check("rst_rdy0", req0_ready_o, 0);
        check("rst_en", cu_enable_o, 0);
        check("rst_op", cu_operator_o, 0);
        check("rst_err", rsp_err_o, 0);
        rst = 0;
        #1;
        check("t1_rdy0", req0_ready_o, 1);
        check("t1_rdy1", req1_ready_o, 0);
        step(1);
        req0_valid_i = 0;
        #1;
        check("t1_en", cu_enable_o, 1);
        check("t1_op", cu_operator_o, ALU_SLTS);
        check("t1_a", cu_operand_a_o, 5);
        check("t1_b", cu_operand_b_o, 7);
        step(1);
        check("t1_en_off", cu_enable_o, 0);
        check("t1_rv0_early", rsp0_valid_o, 0);
        step(1);
        check("t1_rv0", rsp0_valid_o, 1);
        check("t1_data", rsp_data_o, 10);
        check("t1_err", rsp_err_o, 0);
        check("t1_rv1", rsp1_valid_o, 0);
        step(1);
        check("t1_done", rsp0_valid_o, 0);

        // Multicycle op from req1; unit answers on the last WAIT cycle before the abort.
        req1_valid_i = 1; req1_op_i = ALU_CLB; req1_a_i = 48; req1_b_i = 18; cu_ready_i = 0;
        #1;
        check("t2_rdy1", req1_ready_o, 1);
        step(1);
        req1_valid_i = 0;
        step(7);
        check("t2_op_held", cu_operator_o, ALU_CLB);
        check("t2_a_held", cu_operand_a_o, 48);
        check("t2_rv1_wait", rsp1_valid_o, 0);
        cu_ready_i = 1; cu_result_i = 6;
        #1;
        check("t2_rv1_pre", rsp1_valid_o, 0);
        step(1);
        check("t2_rv1", rsp1_valid_o, 1);
        check("t2_data", rsp_data_o, 6);
        check("t2_err", rsp_err_o, 0);
        check("t2_rv0", rsp0_valid_o, 0);
        step(1);

        // Fairness with both requesters continuously valid.
        cu_result_i = 32'h55;
        req0_valid_i = 1; req0_op_i = 7'd1; req0_a_i = 1; req0_b_i = 2;
        req1_valid_i = 1; req1_op_i = 7'd2; req1_a_i = 3; req1_b_i = 4;
        #1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!(req0_ready_o || req1_ready_o) && n < 20) begin
                step(1);
                n++;
            end
            check("fair_bound", n < 20, 1);
            check("fair_grant1", req1_ready_o, exp_order[i]);
            check("fair_grant0", req0_ready_o, !exp_order[i]);
            step(1);
        end
        req0_valid_i = 0; req1_valid_i = 0;
        step(4);

        // Response backpressure while req1 waits.
        rsp0_ready_i = 0;
        req0_valid_i = 1; req0_op_i = 7'h11; req0_a_i = 1; req0_b_i = 2;
        cu_ready_i = 1; cu_result_i = 32'hDEADBEEF;
        #1;
        check("t4_rdy0", req0_ready_o, 1);
        step(1);
        req0_valid_i = 0;
        req1_valid_i = 1; req1_op_i = 7'h22; req1_a_i = 8; req1_b_i = 9;
        step(2);
        for (int i = 0; i < 10; i++) begin
            check("t4_rv0_held", rsp0_valid_o, 1);
            check("t4_data_held", rsp_data_o, 32'hDEADBEEF);
            check("t4_rdy1_blocked", req1_ready_o, 0);
            step(1);
        end
        rsp0_ready_i = 1;
        step(1);
        check("t4_rdy1_after", req1_ready_o, 1);
        step(1);
        req1_valid_i = 0;
        step(3);

        // Watchdog abort, then drain until the unit is ready again.
        cu_ready_i = 0;
        req0_valid_i = 1; req0_op_i = 7'h33; req0_a_i = 32'h1234; req0_b_i = 32'h5678;
        step(1);
        req0_valid_i = 0;
        step(8);
        check("t5_rv0_wait8", rsp0_valid_o, 0);
        step(1);
        check("t5_rv0", rsp0_valid_o, 1);
        check("t5_err", rsp_err_o, 1);
        check("t5_data", rsp_data_o, 0);
        req1_valid_i = 1; req1_op_i = 7'h44; req1_a_i = 2; req1_b_i = 3;
        step(1);
        for (int i = 0; i < 3; i++) begin
            check("t5_drain_rdy1", req1_ready_o, 0);
            check("t5_drain_en", cu_enable_o, 0);
            step(1);
        end
        cu_ready_i = 1; cu_result_i = 7;
        #1;
        check("t5_drain_last", req1_ready_o, 0);
        step(1);
        check("t5_rdy1_after", req1_ready_o, 1);
        step(1);
        req1_valid_i = 0;
        step(3);

        // Asynchronous reset during WAIT.
        cu_ready_i = 0;
        req0_valid_i = 1; req0_op_i = 7'h55; req0_a_i = 9; req0_b_i = 9;
        step(1);
        req0_valid_i = 0;
        step(2);
        rst = 1;
        #1;
        check("t6_op", cu_operator_o, 0);
        check("t6_a", cu_operand_a_o, 0);
        check("t6_rv0", rsp0_valid_o, 0);
        check("t6_en", cu_enable_o, 0);
        req1_valid_i = 1; req1_op_i = 7'h66; req1_a_i = 4; req1_b_i = 5;
        #1;
        check("t6_rdy1_rst", req1_ready_o, 0);
        step(2);
        rst = 0;
        #1;
        check("t6_rdy1", req1_ready_o, 1);
        check("t6_rdy0", req0_ready_o, 0);
        step(1);
        req1_valid_i = 0; cu_ready_i = 1;
        step(3);

        // First tie after reset goes to req0.
        rst = 1;
        step(1);
        req0_valid_i = 1; req1_valid_i = 1;
        rst = 0;
        #1;
        check("t7_tie_rdy0", req0_ready_o, 1);
        check("t7_tie_rdy1", req1_ready_o, 0);
        step(1);
        req0_valid_i = 0; req1_valid_i = 0;
        step(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
